// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - core data bus and store-trace handshake bundle
// Purpose: groups the core-side data bus (store strobe, address, store data,
//   load data), the result mailbox flags and the store-trace stream.
// Signals:
//   MemWrite, DataAdr[ADDR_W], WriteData[DATA_W]  core -> responder
//   ReadData[DATA_W], done, pass                   responder -> core
//   trace_valid, trace_adr, trace_data, trace_ovf  responder -> host
//   trace_ready                                    host -> responder
// Modports: master (core/host side), slave (responder side).
interface data_mem_responder_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
);
  logic              MemWrite;
  logic [ADDR_W-1:0] DataAdr;
  logic [DATA_W-1:0] WriteData;
  logic [DATA_W-1:0] ReadData;
  logic              done;
  logic              pass;
  logic              trace_valid;
  logic              trace_ready;
  logic [ADDR_W-1:0] trace_adr;
  logic [DATA_W-1:0] trace_data;
  logic              trace_ovf;

  modport master (
    output MemWrite, DataAdr, WriteData, trace_ready,
    input  ReadData, done, pass, trace_valid, trace_adr, trace_data, trace_ovf
  );

  modport slave (
    input  MemWrite, DataAdr, WriteData, trace_ready,
    output ReadData, done, pass, trace_valid, trace_adr, trace_data, trace_ovf
  );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data RAM, result mailbox and store-trace FIFO for the core data bus
// Purpose: memory-side responder for the core's 16-bit data bus. Holds the
//   data RAM (registered, write-first loads), decodes the result mailbox and,
//   when TRACE_FIFO_EN is defined, logs every non-scratch store in a FIFO.
// Ports:
//   clk    in  single clock, all state on rising edge
//   reset  in  asynchronous assert, active-high
//   bus    data_mem_responder_if.slave (MemWrite/DataAdr/WriteData -> ReadData,
//          done/pass mailbox flags, trace_* stream)
// Configuration macro: TRACE_FIFO_EN. When undefined the trace_* outputs are
//   tied 0 and trace_ready is ignored; RAM and mailbox behave identically.
module data_mem_responder #(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 256,
  parameter int MBOX_ADR    = 55,
  parameter int PASS_VAL    = 1,
  parameter int SCRATCH_ADR = 96,
  parameter int TRACE_DEPTH = 8
) (
  input logic                clk,
  input logic                reset,
  data_mem_responder_if.slave bus
);
  localparam int                RAM_AW = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] MBOX_A  = ADDR_W'(MBOX_ADR);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  logic [DATA_W-1:0] ram [DEPTH];
  logic [DATA_W-1:0] read_q;
  logic              done_q;
  logic              pass_q;
  logic              is_mbox;
  logic              is_ram;
  logic [RAM_AW-1:0] ram_idx;
  logic [DATA_W-1:0] mbox_status;

  // The mailbox lives inside the RAM address range but is not backed by RAM.
  assign is_mbox     = (bus.DataAdr == MBOX_A);
  assign is_ram      = (bus.DataAdr < DEPTH_A) && !is_mbox;
  assign ram_idx     = bus.DataAdr[RAM_AW-1:0];
  assign mbox_status = {{(DATA_W-2){1'b0}}, pass_q, done_q};

  always_ff @(posedge clk) begin
    if (bus.MemWrite && is_ram) begin
      ram[ram_idx] <= bus.WriteData;
    end
  end

  // Write-first: a load that coincides with a store to the same word sees the new data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_q <= '0;
    end else if (is_mbox) begin
      read_q <= mbox_status;
    end else if (!is_ram) begin
      read_q <= '0;
    end else if (bus.MemWrite) begin
      read_q <= bus.WriteData;
    end else begin
      read_q <= ram[ram_idx];
    end
  end

  // First mailbox store wins; later ones are ignored until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else if (bus.MemWrite && is_mbox && !done_q) begin
      done_q <= 1'b1;
      pass_q <= (bus.WriteData == DATA_W'(PASS_VAL));
    end
  end

  assign bus.ReadData = read_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;

`ifdef TRACE_FIFO_EN
  localparam int                PW        = $clog2(TRACE_DEPTH);
  localparam int                CW        = PW + 1;
  localparam logic [CW-1:0]     FULL_CNT  = CW'(TRACE_DEPTH);
  localparam logic [ADDR_W-1:0] SCRATCH_A = ADDR_W'(SCRATCH_ADR);

  logic [ADDR_W-1:0] tr_adr_mem  [TRACE_DEPTH];
  logic [DATA_W-1:0] tr_data_mem [TRACE_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              ovf_q;
  logic              push_req;
  logic              pop;
  logic              push;

  assign push_req = bus.MemWrite && (bus.DataAdr != SCRATCH_A);
  assign pop      = (count != '0) && bus.trace_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push     = push_req && ((count != FULL_CNT) || pop);

  always_ff @(posedge clk) begin
    if (push) begin
      tr_adr_mem[wr_ptr]  <= bus.DataAdr;
      tr_data_mem[wr_ptr] <= bus.WriteData;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (!push && pop) begin
        count <= count - CW'(1);
      end
      if (push_req && !push) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Valid comes from the registered count, so a push into an empty FIFO
  // shows up one cycle later and never falls through.
  assign bus.trace_valid = (count != '0);
  assign bus.trace_adr   = tr_adr_mem[rd_ptr];
  assign bus.trace_data  = tr_data_mem[rd_ptr];
  assign bus.trace_ovf   = ovf_q;
`else
  logic unused_ok;
  assign unused_ok = bus.trace_ready ^ (bus.DataAdr == ADDR_W'(SCRATCH_ADR))
                     ^ (TRACE_DEPTH != 0);

  assign bus.trace_valid = 1'b0;
  assign bus.trace_adr   = '0;
  assign bus.trace_data  = '0;
  assign bus.trace_ovf   = 1'b0;
`endif
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder (TRACE_FIFO_EN aware)
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_mem_responder_if #(.ADDR_W(13), .DATA_W(16)) bus ();
  data_mem_responder dut (.clk(clk), .reset(reset), .bus(bus));

  int checks   = 0;
  int failures = 0;

  logic [15:0] rd_q [$];
  logic [28:0] tr_q [$];
  logic [15:0] exp16;
  logic [28:0] exp_tr;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    reset           = 1'b1;
    bus.MemWrite    = 1'b0;
    bus.DataAdr     = '0;
    bus.WriteData   = '0;
    bus.trace_ready = 1'b0;
    rd_q.delete();
    tr_q.delete();
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic note_trace(input logic [12:0] adr, input logic [15:0] data);
`ifdef TRACE_FIFO_EN
    if (adr != 13'd96 && tr_q.size() < 8) tr_q.push_back({adr, data});
`endif
  endtask

  task automatic do_store(input logic [12:0] adr, input logic [15:0] data);
    bus.MemWrite  = 1'b1;
    bus.DataAdr   = adr;
    bus.WriteData = data;
    note_trace(adr, data);
    step();
    bus.MemWrite = 1'b0;
  endtask

  task automatic do_load(input logic [12:0] adr, input logic [15:0] exp);
    bus.MemWrite = 1'b0;
    bus.DataAdr  = adr;
    rd_q.push_back(exp);
    step();
  endtask

  task automatic do_store_load(input logic [12:0] adr, input logic [15:0] data);
    bus.MemWrite  = 1'b1;
    bus.DataAdr   = adr;
    bus.WriteData = data;
    note_trace(adr, data);
    rd_q.push_back(data);
    step();
    bus.MemWrite = 1'b0;
  endtask

  task automatic test_reset;
    bus.MemWrite    = 1'b0;
    bus.DataAdr     = 13'd0;
    bus.WriteData   = 16'd0;
    bus.trace_ready = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if (bus.ReadData !== 16'd0) begin failures++; $display("FAIL reset_readdata got=%h exp=0000", bus.ReadData); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.pass !== 1'b0) begin failures++; $display("FAIL reset_pass got=%b exp=0", bus.pass); end
    checks++; if (bus.trace_valid !== 1'b0) begin failures++; $display("FAIL reset_trace_valid got=%b exp=0", bus.trace_valid); end
    checks++; if (bus.trace_ovf !== 1'b0) begin failures++; $display("FAIL reset_trace_ovf got=%b exp=0", bus.trace_ovf); end
    apply_reset();
  endtask

  task automatic test_load_store;
    apply_reset();
    do_store(13'd10, 16'h1234);
    do_load(13'd10, 16'h1234);
    exp16 = rd_q.pop_front();
    checks++; if (bus.ReadData !== exp16) begin failures++; $display("FAIL load_10 got=%h exp=%h", bus.ReadData, exp16); end
    do_store_load(13'd20, 16'hBEEF);
    exp16 = rd_q.pop_front();
    checks++; if (bus.ReadData !== exp16) begin failures++; $display("FAIL write_first_20 got=%h exp=%h", bus.ReadData, exp16); end
    do_store(13'd44, 16'h4444);
    do_store(13'd300, 16'hAAAA);
    do_load(13'd300, 16'h0000);
    exp16 = rd_q.pop_front();
    checks++; if (bus.ReadData !== exp16) begin failures++; $display("FAIL load_unmapped_300 got=%h exp=%h", bus.ReadData, exp16); end
    do_load(13'd44, 16'h4444);
    exp16 = rd_q.pop_front();
    checks++; if (bus.ReadData !== exp16) begin failures++; $display("FAIL no_alias_44 got=%h exp=%h", bus.ReadData, exp16); end
    do_load(13'd20, 16'hBEEF);
    exp16 = rd_q.pop_front();
    checks++; if (bus.ReadData !== exp16) begin failures++; $display("FAIL load_20 got=%h exp=%h", bus.ReadData, exp16); end
  endtask

  task automatic test_mailbox_pass;
    apply_reset();
    do_store(13'd55, 16'd1);
    checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL mbox_done got=%b exp=1", bus.done); end
    checks++; if (bus.pass !== 1'b1) begin failures++; $display("FAIL mbox_pass got=%b exp=1", bus.pass); end
    do_store(13'd55, 16'd7);
    checks++; if (bus.pass !== 1'b1) begin failures++; $display("FAIL mbox_first_wins got=%b exp=1", bus.pass); end
    do_load(13'd55, 16'h0003);
    exp16 = rd_q.pop_front();
    checks++; if (bus.ReadData !== exp16) begin failures++; $display("FAIL mbox_read got=%h exp=%h", bus.ReadData, exp16); end
  endtask

  task automatic test_mailbox_fail;
    apply_reset();
    do_store(13'd55, 16'd2);
    checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL mbox_fail_done got=%b exp=1", bus.done); end
    checks++; if (bus.pass !== 1'b0) begin failures++; $display("FAIL mbox_fail_pass got=%b exp=0", bus.pass); end
    do_store(13'd96, 16'd5);
    do_store(13'd55, 16'd1);
    checks++; if (bus.pass !== 1'b0) begin failures++; $display("FAIL mbox_fail_sticky got=%b exp=0", bus.pass); end
    do_load(13'd96, 16'd5);
    exp16 = rd_q.pop_front();
    checks++; if (bus.ReadData !== exp16) begin failures++; $display("FAIL scratch_read got=%h exp=%h", bus.ReadData, exp16); end
    do_load(13'd55, 16'h0001);
    exp16 = rd_q.pop_front();
    checks++; if (bus.ReadData !== exp16) begin failures++; $display("FAIL mbox_fail_read got=%h exp=%h", bus.ReadData, exp16); end
`ifdef TRACE_FIFO_EN
    // Expected trace: {55,2} then {55,1}; the scratch store is absent.
    bus.trace_ready = 1'b1;
    for (int n = 0; n < 4 && tr_q.size() > 0; n++) begin
      exp_tr = tr_q.pop_front();
      checks++; if (bus.trace_valid !== 1'b1) begin failures++; $display("FAIL scratch_trace_valid got=%b exp=1", bus.trace_valid); end
      checks++; if ({bus.trace_adr, bus.trace_data} !== exp_tr) begin failures++; $display("FAIL scratch_trace_head got=%h exp=%h", {bus.trace_adr, bus.trace_data}, exp_tr); end
      step();
    end
    bus.trace_ready = 1'b0;
    checks++; if (bus.trace_valid !== 1'b0) begin failures++; $display("FAIL scratch_trace_empty got=%b exp=0", bus.trace_valid); end
`endif
  endtask

`ifdef TRACE_FIFO_EN
  task automatic test_trace_overflow;
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      do_store(13'(i), 16'(16'h0100 + i));
      if (i == 7) begin
        checks++; if (bus.trace_ovf !== 1'b0) begin failures++; $display("FAIL ovf_early got=%b exp=0", bus.trace_ovf); end
      end
    end
    checks++; if (bus.trace_ovf !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", bus.trace_ovf); end
    exp_tr = tr_q[0];
    step();
    checks++; if ({bus.trace_adr, bus.trace_data} !== exp_tr) begin failures++; $display("FAIL head_stable got=%h exp=%h", {bus.trace_adr, bus.trace_data}, exp_tr); end
    bus.trace_ready = 1'b1;
    for (int n = 0; n < 12 && tr_q.size() > 0; n++) begin
      exp_tr = tr_q.pop_front();
      checks++; if (bus.trace_valid !== 1'b1) begin failures++; $display("FAIL drain_valid got=%b exp=1", bus.trace_valid); end
      checks++; if ({bus.trace_adr, bus.trace_data} !== exp_tr) begin failures++; $display("FAIL drain_head got=%h exp=%h", {bus.trace_adr, bus.trace_data}, exp_tr); end
      step();
    end
    bus.trace_ready = 1'b0;
    checks++; if (bus.trace_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%b exp=0", bus.trace_valid); end
  endtask

  task automatic test_full_pop_push;
    apply_reset();
    do_store(13'd55, 16'd1);
    for (int i = 0; i < 7; i++) do_store(13'(16 + i), 16'(16'h0200 + i));
    checks++; if (bus.trace_ovf !== 1'b0) begin failures++; $display("FAIL full_no_ovf got=%b exp=0", bus.trace_ovf); end
    bus.trace_ready = 1'b1;
    exp_tr = tr_q.pop_front();
    checks++; if ({bus.trace_adr, bus.trace_data} !== exp_tr) begin failures++; $display("FAIL full_pop_head got=%h exp=%h", {bus.trace_adr, bus.trace_data}, exp_tr); end
    do_store(13'd40, 16'hC0DE);
    bus.trace_ready = 1'b0;
    checks++; if (bus.trace_ovf !== 1'b0) begin failures++; $display("FAIL pop_push_ovf got=%b exp=0", bus.trace_ovf); end
    do_store(13'd41, 16'hDEAD);
    checks++; if (bus.trace_ovf !== 1'b1) begin failures++; $display("FAIL count_stays_8 got=%b exp=1", bus.trace_ovf); end
    bus.trace_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      exp_tr = tr_q.pop_front();
      checks++; if ({bus.trace_adr, bus.trace_data} !== exp_tr) begin failures++; $display("FAIL mid_drain_head got=%h exp=%h", {bus.trace_adr, bus.trace_data}, exp_tr); end
      step();
    end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (bus.trace_valid !== 1'b0) begin failures++; $display("FAIL async_reset_valid got=%b exp=0", bus.trace_valid); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL async_reset_done got=%b exp=0", bus.done); end
    bus.trace_ready = 1'b0;
    apply_reset();
    checks++; if (bus.trace_valid !== 1'b0) begin failures++; $display("FAIL post_reset_empty got=%b exp=0", bus.trace_valid); end
  endtask
`else
  task automatic test_trace_disabled;
    apply_reset();
    bus.trace_ready = 1'b1;
    do_store(13'd55, 16'd1);
    for (int i = 0; i < 10; i++) begin
      do_store(13'(i), 16'(16'h0300 + i));
      checks++; if ({bus.trace_valid, bus.trace_ovf, bus.trace_adr, bus.trace_data} !== 31'd0) begin failures++; $display("FAIL trace_tied_zero got=%h exp=0", {bus.trace_valid, bus.trace_ovf, bus.trace_adr, bus.trace_data}); end
    end
    do_load(13'd3, 16'h0303);
    exp16 = rd_q.pop_front();
    checks++; if (bus.ReadData !== exp16) begin failures++; $display("FAIL disabled_ram got=%h exp=%h", bus.ReadData, exp16); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL async_reset_done got=%b exp=0", bus.done); end
    apply_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_load_store();
    test_mailbox_pass();
    test_mailbox_fail();
`ifdef TRACE_FIFO_EN
    test_trace_overflow();
    test_full_pop_push();
`else
    test_trace_disabled();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
